sb_param_shadow_cfg: RTL and testbench

- Parametrised successor to the fixed-width, bl/wl-programmed unique switch blocks.
- Covers a bottom-edge switch block (top and left sides) with CHAN_W tracks per side and MUX_SIZE-input routing muxes.
- Mux selects live in an internal double-buffered configuration store. A request/ready frame interface writes and reads a shadow bank; an atomic commit copies shadow to active, so the fabric is never driven by a half-written configuration.

---
 rtl/sb_param_shadow_cfg.sv | 150 +++++++++++++++
 tb/tb_sb_param_shadow_cfg.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_param_shadow_cfg.sv
// Parametrised bottom-edge switch block (top and left sides).
// Mux selects come from a double-buffered store: a frame interface
// reads/writes the shadow bank, and an atomic commit copies shadow to
// active so the routing muxes never see a half-written configuration.
module sb_param_shadow_cfg #(
  parameter  int CHAN_W   = 9,
  parameter  int MUX_SIZE = 2,
  localparam int SEL_W    = $clog2(MUX_SIZE),
  localparam int NMUX     = 2 * CHAN_W,
  localparam int ADDR_W   = $clog2(NMUX)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic [CHAN_W-1:0] chany_top_in,
  input  logic [CHAN_W-1:0] chanx_left_in,
  input  logic [CHAN_W-1:0] top_grid_pin,
  input  logic [CHAN_W-1:0] left_grid_pin,
  output logic [CHAN_W-1:0] chany_top_out,
  output logic [CHAN_W-1:0] chanx_left_out,
  input  logic              cfg_valid,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [SEL_W-1:0]  cfg_wdata,
  input  logic              cfg_rsel,
  output logic              cfg_ready,
  output logic [SEL_W-1:0]  cfg_rdata,
  output logic              cfg_rvalid,
  input  logic              cfg_commit,
  input  logic              cfg_lock,
  output logic              cfg_locked,
  output logic              cfg_err
);

  // Select values at or above this limit drive the mux output low.
  localparam logic [SEL_W:0]  MUX_LIM  = (SEL_W + 1)'(MUX_SIZE);
  localparam logic [ADDR_W:0] NMUX_LIM = (ADDR_W + 1)'(NMUX);

  typedef enum logic [1:0] {IDLE, WRITE, READ, COMMIT} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [SEL_W-1:0]    wdata_q;
  logic                rsel_q;
  logic                locked_q;
  logic [SEL_W-1:0]    rdata_q;
  logic                rvalid_q;
  logic                err_q;
  logic [SEL_W-1:0]    shadow_q [NMUX];
  logic [SEL_W-1:0]    active_q [NMUX];
  logic [1:0]          rst_sync_q;
  logic                rst_n_int;
  logic                addr_ok;

  // Reset asserts asynchronously but releases on a clock edge, so the
  // configuration state never leaves reset mid-cycle.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];
  assign addr_ok   = ({1'b0, addr_q} < NMUX_LIM);

  // Routing muxes: input 0 is the grid pin, input k>=1 taps the
  // opposite-side channel with a per-track rotation.
  genvar gi, gk;
  generate
    for (gi = 0; gi < CHAN_W; gi++) begin : g_mux
      logic [MUX_SIZE-1:0] top_in_w;
      logic [MUX_SIZE-1:0] left_in_w;
      assign top_in_w[0]  = top_grid_pin[gi];
      assign left_in_w[0] = left_grid_pin[gi];
      for (gk = 1; gk < MUX_SIZE; gk++) begin : g_in
        localparam int IDX = (CHAN_W - gi + gk - 1) % CHAN_W;
        assign top_in_w[gk]  = chanx_left_in[IDX];
        assign left_in_w[gk] = chany_top_in[IDX];
      end
      assign chany_top_out[gi]  = ({1'b0, active_q[gi]} < MUX_LIM) ?
                                  top_in_w[active_q[gi]] : 1'b0;
      assign chanx_left_out[gi] = ({1'b0, active_q[CHAN_W+gi]} < MUX_LIM) ?
                                  left_in_w[active_q[CHAN_W+gi]] : 1'b0;
    end
  endgenerate

  // Commit takes priority over a same-cycle frame request.
  assign cfg_ready  = (state_q == IDLE) & ~cfg_commit;
  assign cfg_rdata  = rdata_q;
  assign cfg_rvalid = rvalid_q;
  assign cfg_locked = locked_q;
  assign cfg_err    = err_q;

  // Frame FSM with both config banks, sticky lock and registered status.
  always_ff @(posedge prog_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rsel_q   <= 1'b0;
      locked_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < NMUX; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      if (cfg_lock) locked_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (cfg_commit) begin
            state_q <= COMMIT;
          end else if (cfg_valid) begin
            addr_q  <= cfg_addr;
            wdata_q <= cfg_wdata;
            rsel_q  <= cfg_rsel;
            state_q <= cfg_we ? WRITE : READ;
          end
        end
        WRITE: begin
          if (addr_ok && !locked_q) shadow_q[addr_q] <= wdata_q;
          else                      err_q <= 1'b1;
          state_q <= IDLE;
        end
        READ: begin
          rvalid_q <= 1'b1;
          if (addr_ok) begin
            rdata_q <= rsel_q ? active_q[addr_q] : shadow_q[addr_q];
          end else begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
          state_q <= IDLE;
        end
        COMMIT: begin
          if (!locked_q) begin
            for (int i = 0; i < NMUX; i++) active_q[i] <= shadow_q[i];
          end else begin
            err_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_param_shadow_cfg.sv
// Directed bench for sb_param_shadow_cfg: one 9-track/2-input instance
// and one 4-track/4-input instance sharing a clock.
module tb_sb_param_shadow_cfg;

  logic prog_clk;
  int   total = 0;
  int   bad   = 0;

  // Instance A: CHAN_W=9, MUX_SIZE=2 (SEL_W=1, NMUX=18, ADDR_W=5)
  logic       a_rst_n;
  logic [8:0] a_ty_in, a_lx_in, a_tg, a_lg, a_top_out, a_left_out;
  logic       a_valid, a_we, a_rsel, a_ready, a_rvalid, a_commit, a_lock, a_locked, a_err;
  logic [4:0] a_addr;
  logic       a_wdata, a_rdata;

  // Instance B: CHAN_W=4, MUX_SIZE=4 (SEL_W=2, NMUX=8, ADDR_W=3)
  logic       b_rst_n;
  logic [3:0] b_ty_in, b_lx_in, b_tg, b_lg, b_top_out, b_left_out;
  logic       b_valid, b_we, b_rsel, b_ready, b_rvalid, b_commit, b_lock, b_locked, b_err;
  logic [2:0] b_addr;
  logic [1:0] b_wdata, b_rdata;

  sb_param_shadow_cfg #(.CHAN_W(9), .MUX_SIZE(2)) u_a (
    .prog_clk(prog_clk), .pReset_n(a_rst_n),
    .chany_top_in(a_ty_in), .chanx_left_in(a_lx_in),
    .top_grid_pin(a_tg), .left_grid_pin(a_lg),
    .chany_top_out(a_top_out), .chanx_left_out(a_left_out),
    .cfg_valid(a_valid), .cfg_we(a_we), .cfg_addr(a_addr), .cfg_wdata(a_wdata),
    .cfg_rsel(a_rsel), .cfg_ready(a_ready), .cfg_rdata(a_rdata), .cfg_rvalid(a_rvalid),
    .cfg_commit(a_commit), .cfg_lock(a_lock), .cfg_locked(a_locked), .cfg_err(a_err)
  );

  sb_param_shadow_cfg #(.CHAN_W(4), .MUX_SIZE(4)) u_b (
    .prog_clk(prog_clk), .pReset_n(b_rst_n),
    .chany_top_in(b_ty_in), .chanx_left_in(b_lx_in),
    .top_grid_pin(b_tg), .left_grid_pin(b_lg),
    .chany_top_out(b_top_out), .chanx_left_out(b_left_out),
    .cfg_valid(b_valid), .cfg_we(b_we), .cfg_addr(b_addr), .cfg_wdata(b_wdata),
    .cfg_rsel(b_rsel), .cfg_ready(b_ready), .cfg_rdata(b_rdata), .cfg_rvalid(b_rvalid),
    .cfg_commit(b_commit), .cfg_lock(b_lock), .cfg_locked(b_locked), .cfg_err(b_err)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired, total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  task automatic cyc();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A helpers ----------------
  task automatic a_wait_ready();
    for (int i = 0; i < 20 && !a_ready; i++) cyc();
    chk("a_ready_timeout", 32'(a_ready), 32'd1);
  endtask

  task automatic a_write(input logic [4:0] addr, input logic wd, output logic err);
    a_valid = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = wd;
    #1 a_wait_ready();
    cyc();
    a_valid = 1'b0;
    cyc();
    err = a_err;
    $display("A write addr=%0d data=%0d err=%0b", addr, wd, err);
  endtask

  task automatic a_read(input logic [4:0] addr, input logic rs,
                        output logic rd, output logic rv, output logic err);
    a_valid = 1'b1; a_we = 1'b0; a_addr = addr; a_rsel = rs;
    #1 a_wait_ready();
    cyc();
    a_valid = 1'b0;
    cyc();
    rd = a_rdata; rv = a_rvalid; err = a_err;
    $display("A read addr=%0d rsel=%0b rdata=%0h rvalid=%0b err=%0b", addr, rs, rd, rv, err);
  endtask

  task automatic a_do_commit(output logic err);
    a_commit = 1'b1;
    cyc();
    a_commit = 1'b0;
    cyc();
    err = a_err;
    $display("A commit err=%0b top_out=%0h left_out=%0h", err, a_top_out, a_left_out);
  endtask

  // ---------------- instance B helpers ----------------
  task automatic b_wait_ready();
    for (int i = 0; i < 20 && !b_ready; i++) cyc();
    chk("b_ready_timeout", 32'(b_ready), 32'd1);
  endtask

  task automatic b_write(input logic [2:0] addr, input logic [1:0] wd, output logic err);
    b_valid = 1'b1; b_we = 1'b1; b_addr = addr; b_wdata = wd;
    #1 b_wait_ready();
    cyc();
    b_valid = 1'b0;
    cyc();
    err = b_err;
    $display("B write addr=%0d data=%0d err=%0b", addr, wd, err);
  endtask

  task automatic b_read(input logic [2:0] addr, input logic rs,
                        output logic [1:0] rd, output logic rv);
    b_valid = 1'b1; b_we = 1'b0; b_addr = addr; b_rsel = rs;
    #1 b_wait_ready();
    cyc();
    b_valid = 1'b0;
    cyc();
    rd = b_rdata; rv = b_rvalid;
    $display("B read addr=%0d rsel=%0b rdata=%0h rvalid=%0b", addr, rs, rd, rv);
  endtask

  task automatic b_do_commit(output logic err);
    b_commit = 1'b1;
    cyc();
    b_commit = 1'b0;
    cyc();
    err = b_err;
    $display("B commit err=%0b top_out=%0h left_out=%0h", err, b_top_out, b_left_out);
  endtask

  initial begin : stim
    logic       e, rv, rd1;
    logic [1:0] rd2;

    a_rst_n = 1'b0; a_ty_in = '0; a_lx_in = '0; a_tg = 9'h1A5; a_lg = 9'h05A;
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = 1'b0; a_rsel = 1'b0;
    a_commit = 1'b0; a_lock = 1'b0;
    b_rst_n = 1'b0; b_ty_in = '0; b_lx_in = '0; b_tg = 4'h5; b_lg = 4'hA;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_rsel = 1'b0;
    b_commit = 1'b0; b_lock = 1'b0;

    // ---- A: post-reset state ----
    repeat (2) cyc();
    a_rst_n = 1'b1;
    repeat (3) cyc();
    chk("a_rst_top_out",  32'(a_top_out),  32'h1A5);
    chk("a_rst_left_out", 32'(a_left_out), 32'h05A);
    chk("a_rst_ready",    32'(a_ready),    32'd1);
    chk("a_rst_locked",   32'(a_locked),   32'd0);
    chk("a_rst_rvalid",   32'(a_rvalid),   32'd0);
    chk("a_rst_err",      32'(a_err),      32'd0);
    chk("a_rst_rdata",    32'(a_rdata),    32'd0);

    // ---- A: shadow isolation and commit ----
    a_lx_in = 9'h100;                      // chanx_left_in[8] = 1
    a_write(5'd1, 1'b1, e);
    chk("a_wr1_err",      32'(e),         32'd0);
    chk("a_wr1_isolated", 32'(a_top_out), 32'h1A5);
    a_read(5'd1, 1'b0, rd1, rv, e);
    chk("a_rd_shadow1",   32'(rd1),       32'd1);
    chk("a_rd_shadow1_v", 32'(rv),        32'd1);
    a_read(5'd1, 1'b1, rd1, rv, e);
    chk("a_rd_active1",   32'(rd1),       32'd0);
    chk("a_rvalid_pulse_end", 32'(a_rvalid), 32'd1);
    cyc();
    chk("a_rvalid_pulse_clr", 32'(a_rvalid), 32'd0);
    chk("a_rdata_hold",   32'(a_rdata),   32'd0);
    a_do_commit(e);
    chk("a_commit1_err",  32'(e),         32'd0);
    chk("a_commit1_out",  32'(a_top_out), 32'h1A7);

    // ---- A: boundary address ----
    a_write(5'd18, 1'b1, e);
    chk("a_wr18_err",     32'(e),         32'd1);
    cyc();
    chk("a_wr18_err_pulse", 32'(a_err),   32'd0);
    a_read(5'd0, 1'b0, rd1, rv, e);
    chk("a_rd0_unchanged", 32'(rd1),      32'd0);
    a_read(5'd1, 1'b0, rd1, rv, e);
    chk("a_rd1_unchanged", 32'(rd1),      32'd1);
    a_read(5'd18, 1'b0, rd1, rv, e);
    chk("a_rd18_rvalid",  32'(rv),        32'd1);
    chk("a_rd18_rdata",   32'(rd1),       32'd0);
    chk("a_rd18_err",     32'(e),         32'd1);

    // ---- A: commit and write request in the same cycle ----
    a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd2; a_wdata = 1'b1; a_commit = 1'b1;
    #1 chk("a_simul_ready", 32'(a_ready), 32'd0);
    cyc();
    a_commit = 1'b0;
    #1 chk("a_commit_busy_ready", 32'(a_ready), 32'd0);
    cyc();                                 // commit edge: shadow[2] still 0
    chk("a_simul_out_hold", 32'(a_top_out), 32'h1A7);
    chk("a_simul_err",      32'(a_err),     32'd0);
    chk("a_idle_ready",     32'(a_ready),   32'd1);
    cyc();                                 // write accepted now
    a_valid = 1'b0;
    cyc();                                 // shadow[2] <= 1
    $display("A deferred write addr=2 data=1 err=%0b", a_err);
    chk("a_simul_wr_err",   32'(a_err),     32'd0);
    chk("a_simul_pre_commit", 32'(a_top_out), 32'h1A7);
    a_do_commit(e);
    // mux 2 select 1 -> chanx_left_in[7] = 0, clearing bit 2
    chk("a_simul_post_commit", 32'(a_top_out), 32'h1A3);

    // ---- A: lock ----
    a_ty_in = 9'h001;                      // left mux 0, input 1 -> chany_top_in[0]
    a_write(5'd9, 1'b1, e);
    chk("a_wr9_err",      32'(e),          32'd0);
    a_lock = 1'b1;
    cyc();
    a_lock = 1'b0;
    chk("a_locked",       32'(a_locked),   32'd1);
    a_do_commit(e);
    chk("a_lock_commit_err", 32'(e),       32'd1);
    chk("a_lock_left_out",   32'(a_left_out), 32'h05A);
    chk("a_lock_top_out",    32'(a_top_out),  32'h1A3);
    a_write(5'd0, 1'b1, e);
    chk("a_lock_wr_err",  32'(e),          32'd1);
    a_read(5'd9, 1'b0, rd1, rv, e);
    chk("a_lock_rd_shadow", 32'(rd1),      32'd1);
    chk("a_lock_rd_err",  32'(e),          32'd0);
    a_read(5'd0, 1'b0, rd1, rv, e);
    chk("a_lock_rd0",     32'(rd1),        32'd0);
    a_read(5'd9, 1'b1, rd1, rv, e);
    chk("a_lock_rd_active", 32'(rd1),      32'd0);
    chk("a_still_locked", 32'(a_locked),   32'd1);

    // ---- B: MUX_SIZE=4, CHAN_W=4, reset mid-read ----
    b_lx_in = 4'h8;                        // chanx_left_in[3] = 1
    b_rst_n = 1'b1;
    repeat (3) cyc();
    chk("b_rst_top_out",  32'(b_top_out),  32'h5);
    chk("b_rst_left_out", 32'(b_left_out), 32'hA);
    b_write(3'd3, 2'd3, e);
    chk("b_wr3_err",      32'(e),          32'd0);
    b_do_commit(e);
    chk("b_commit_err",   32'(e),          32'd0);
    chk("b_commit_top",   32'(b_top_out),  32'hD);
    chk("b_commit_left",  32'(b_left_out), 32'hA);

    b_valid = 1'b1; b_we = 1'b0; b_addr = 3'd3; b_rsel = 1'b0;
    #1 b_wait_ready();
    cyc();                                 // read accepted, FSM in READ
    b_valid = 1'b0;
    b_rst_n = 1'b0;
    #1;
    $display("B reset during read: top_out=%0h left_out=%0h rvalid=%0b", b_top_out, b_left_out, b_rvalid);
    chk("b_abort_top",    32'(b_top_out),  32'h5);
    chk("b_abort_left",   32'(b_left_out), 32'hA);
    chk("b_abort_rvalid", 32'(b_rvalid),   32'd0);
    cyc();
    chk("b_abort_rvalid2", 32'(b_rvalid),  32'd0);
    chk("b_abort_rdata",  32'(b_rdata),    32'd0);
    cyc();
    b_rst_n = 1'b1;
    repeat (3) cyc();
    chk("b_post_rvalid",  32'(b_rvalid),   32'd0);
    chk("b_post_ready",   32'(b_ready),    32'd1);
    b_read(3'd3, 1'b0, rd2, rv);
    chk("b_post_shadow",  32'(rd2),        32'd0);
    b_read(3'd3, 1'b1, rd2, rv);
    chk("b_post_active",  32'(rd2),        32'd0);
    chk("b_post_top",     32'(b_top_out),  32'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
